// File: rtl/reg_file.sv
// Vector register file: NoOfElem registers of words*wordSize bits, one
// synchronous write port, every register exposed in parallel on dataOut.
// Optional feature macro: REGFILE_WORD_MASK_EN adds a per-lane write mask
// input (wmask). Without it, every write replaces all lanes.
module reg_file #(
  parameter int unsigned wordSize = 32,
  parameter int unsigned words    = 16,
  parameter int unsigned NoOfElem = 16
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          WE,
  input  logic [$clog2(NoOfElem)-1:0]   addr,
  input  logic [words*wordSize-1:0]     dataIn,
`ifdef REGFILE_WORD_MASK_EN
  input  logic [words-1:0]              wmask,
`endif
  output logic [words*wordSize-1:0]     dataOut [0:NoOfElem-1]
);

  localparam int unsigned ADDR_W = $clog2(NoOfElem);
  localparam int unsigned REG_W  = words * wordSize;

  logic [REG_W-1:0] r_regs [0:NoOfElem-1];
  logic [REG_W-1:0] w_wdata;

  // Merge incoming lanes with the current contents of the addressed register
  always_comb begin
    w_wdata = dataIn;
`ifdef REGFILE_WORD_MASK_EN
    for (int unsigned j = 0; j < words; j++) begin
      if (!wmask[j]) begin
        w_wdata[j*wordSize +: wordSize] = r_regs[addr][j*wordSize +: wordSize];
      end
    end
`endif
  end

  // Storage update: reset clears everything and overrides any write
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_regs <= '{default: '0};
    end else if (WE) begin
      r_regs[addr[ADDR_W-1:0]] <= w_wdata;
    end
  end

  // Registers drive the outputs directly, no bypass path
  assign dataOut = r_regs;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default 16 x 16 x 32b).
// Builds with or without REGFILE_WORD_MASK_EN; the mask test runs only with it.
module tb_reg_file;

  localparam int unsigned WS = 32;
  localparam int unsigned WD = 16;
  localparam int unsigned NE = 16;
  localparam int unsigned RW = WS * WD;

  logic          clk = 1'b0;
  logic          RESET;
  logic          WE;
  logic [3:0]    addr;
  logic [RW-1:0] dataIn;
  logic [WD-1:0] wmask;
  logic [RW-1:0] dout  [0:NE-1];
  logic [RW-1:0] model [0:NE-1];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file #(
    .wordSize (WS),
    .words    (WD),
    .NoOfElem (NE)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .WE      (WE),
    .addr    (addr),
    .dataIn  (dataIn),
`ifdef REGFILE_WORD_MASK_EN
    .wmask   (wmask),
`endif
    .dataOut (dout)
  );

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < NE; i++) chk($sformatf("%s[%0d]", tag, i), dout[i], model[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_vec();
    logic [RW-1:0] v;
    for (int j = 0; j < WD; j++) v[j*WS +: WS] = $urandom;
    return v;
  endfunction

  initial begin
    logic [31:0]   lane;
    logic [RW-1:0] v;

    RESET = 1'b0; WE = 1'b0; addr = '0; dataIn = '0; wmask = '1;

    // 1: preload garbage, then one reset edge
    for (int k = 0; k < NE; k++) begin
      WE = 1'b1; addr = 4'(k); dataIn = rand_vec();
      tick();
    end
    WE = 1'b0; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < NE; i++) model[i] = '0;
    chk_all("reset");

    // 2: fill every register with replicated lane pattern
    for (int k = 0; k < NE; k++) begin
      lane = 32'hFFFF_FFF0 + 32'(k);
      WE = 1'b1; addr = 4'(k); dataIn = {WD{lane}};
      tick();
      WE = 1'b0;
      model[k] = {WD{lane}};
      chk_all($sformatf("fill%0d", k));
    end
    chk("fill_top_ones", dout[15], {RW{1'b1}});
    tick();
    chk_all("fill_hold");

    // 3: WE low, sweep addr with random data; also an unknown addr
    for (int k = 0; k < NE; k++) begin
      addr = 4'(k); dataIn = rand_vec();
      tick();
      chk_all($sformatf("hold%0d", k));
    end
    addr = 'x; dataIn = rand_vec();
    tick();
    chk_all("hold_xaddr");

    // 4: back-to-back writes, last wins; then reset during a write
    WE = 1'b1; addr = 4'd3; dataIn = 512'h1;
    tick();
    chk("ovw_first", dout[3], 512'h1);
    dataIn = 512'h2;
    tick();
    WE = 1'b0;
    model[3] = 512'h2;
    chk_all("ovw_last");
    WE = 1'b1; RESET = 1'b1; addr = 4'd9; dataIn = rand_vec();
    tick();
    WE = 1'b0; RESET = 1'b0;
    for (int i = 0; i < NE; i++) model[i] = '0;
    chk_all("rst_prio");

    // 5: write latency on addr 7
    v = rand_vec();
    WE = 1'b1; addr = 4'd7; dataIn = v;
    @(negedge clk);
    chk("lat_before", dout[7], '0);
    tick();
    WE = 1'b0;
    chk("lat_after", dout[7], v);
    dataIn = rand_vec();
    tick();
    chk("lat_stable", dout[7], v);

`ifdef REGFILE_WORD_MASK_EN
    // 6: masked write keeps unselected lanes
    WE = 1'b1; addr = 4'd5; dataIn = {RW{1'b1}}; wmask = '1;
    tick();
    dataIn = '0; wmask = 16'h00FF;
    tick();
    WE = 1'b0; wmask = '1;
    model[7] = v;
    model[5] = {{(RW/2){1'b1}}, {(RW/2){1'b0}}};
    chk_all("mask");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
